spi_burst_transmit_fsm: RTL and testbench

Burst transmit sequencer on the SPI master's input side, mirroring the burst capture stage on its output side. On a start command it reads `i_burst_count` words from a synchronous input buffer RAM and hands them one at a time to the SPI master. It issues a single-cycle start per word, waits for that word to complete, and inserts an optional programmable gap between words. It reports progress and a completion pulse to the controlling logic.

---
 rtl/spi_burst_transmit_fsm.sv | 166 ++++++++++++++++
 tb/tb_spi_burst_transmit_fsm.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_transmit_fsm.sv
// Burst transmit sequencer: streams i_burst_count words from a synchronous input buffer into
// an SPI master, one start pulse per word, with an optional idle gap between words.
module spi_burst_transmit_fsm #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [15:0]           i_burst_count,
    input  logic                  i_abort,
    output logic                  o_inbuf_re,
    output logic [ADDR_WIDTH-1:0] o_inbuf_addr,
    input  logic [DATA_WIDTH-1:0] i_inbuf_dat,
    output logic                  o_spi_start,
    output logic [DATA_WIDTH-1:0] o_spi_data,
    input  logic                  i_spi_busy,
    input  logic                  i_spi_done,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_word_count
);

    // Gap counter is loaded with GAP_CYCLES-1 and counts down to zero.
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StArm,
        StXfer,
        StGap,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           wcount_q, wcount_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  re_q, re_d;
    logic                  spi_start_q, spi_start_d;
    logic [DATA_WIDTH-1:0] spi_data_q, spi_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [15:0]           next_wcount;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            wcount_q    <= '0;
            addr_q      <= '0;
            re_q        <= 1'b0;
            spi_start_q <= 1'b0;
            spi_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wcount_q    <= wcount_d;
            addr_q      <= addr_d;
            re_q        <= re_d;
            spi_start_q <= spi_start_d;
            spi_data_q  <= spi_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gap_q       <= gap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wcount_d    = wcount_q;
        addr_d      = addr_q;
        re_d        = 1'b0;
        spi_start_d = 1'b0;
        spi_data_d  = spi_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        gap_d       = gap_q;
        next_wcount = wcount_q + 16'd1;

        if (i_abort && (state_q != StIdle)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        count_d = i_burst_count;
                        if (i_burst_count != 16'd0) begin
                            busy_d   = 1'b1;
                            wcount_d = '0;
                            addr_d   = '0;
                            re_d     = 1'b1;
                            state_d  = StRead;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StRead: state_d = StLatch;
                StLatch: begin
                    spi_data_d = i_inbuf_dat;
                    state_d    = StArm;
                end
                StArm: begin
                    if (!i_spi_busy) begin
                        spi_start_d = 1'b1;
                        state_d     = StXfer;
                    end
                end
                StXfer: begin
                    // A done coincident with our own start pulse belongs to the previous word.
                    if (i_spi_done && !spi_start_q) begin
                        wcount_d = next_wcount;
                        if (next_wcount == count_q) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StDone;
                        end else if (GAP_CYCLES == 0) begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            re_d    = 1'b1;
                            state_d = StRead;
                        end else begin
                            gap_d   = GapW'(GAP_CYCLES - 1);
                            state_d = StGap;
                        end
                    end
                end
                StGap: begin
                    if (gap_q == '0) begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        re_d    = 1'b1;
                        state_d = StRead;
                    end else begin
                        gap_d = gap_q - GapW'(1);
                    end
                end
                StDone: begin
                    // A zero-length burst reaches here without a pulse; emit it now.
                    done_d  = (count_q == 16'd0);
                    addr_d  = '0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign o_inbuf_re   = re_q;
    assign o_inbuf_addr = addr_q;
    assign o_spi_start  = spi_start_q;
    assign o_spi_data   = spi_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_word_count = wcount_q;

endmodule

// File: tb/tb_spi_burst_transmit_fsm.sv
// Bench for spi_burst_transmit_fsm: two instances (GAP_CYCLES 0 and 5), each with its own
// buffer port and SPI master model; event cycles are compared against a cycle-arithmetic model.
`timescale 1ns/1ps
module tb_spi_burst_transmit_fsm;

    localparam int Lat  = 10;
    localparam int Hold = 7;
    localparam int LogN = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start  [2];
    logic [15:0] bcount [2];
    logic        abort  [2];
    logic        re     [2];
    logic [15:0] addr   [2];
    logic [15:0] dat    [2];
    logic        sstart [2];
    logic [15:0] sdata  [2];
    logic        sbusy  [2];
    logic        sdone  [2];
    logic        busy   [2];
    logic        done   [2];
    logic [15:0] wcount [2];

    logic [15:0] mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // SPI master model state
    int   spi_cnt   [2];
    bit   spi_act   [2];
    int   spi_tail  [2];
    int   spi_ndone [2];
    int   hold_idx  [2];
    bit   stale_en  [2];
    logic [15:0] hold_exp [2];

    // Event log
    int          re_cyc  [2][LogN];
    logic [15:0] re_adr  [2][LogN];
    int          st_cyc  [2][LogN];
    logic [15:0] st_dat  [2][LogN];
    int          dn_cyc  [2][LogN];
    int          n_re    [2];
    int          n_st    [2];
    int          n_done  [2];
    int          n_busy  [2];
    int          dbl_err [2];
    int          hold_err[2];
    int          hold_n  [2];
    bit          re_prev [2];
    bit          st_prev [2];
    int          last_wc [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_burst_transmit_fsm #(
            .DATA_WIDTH(16),
            .ADDR_WIDTH(16),
            .GAP_CYCLES((g == 0) ? 0 : 5)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_start      (start[g]),
            .i_burst_count(bcount[g]),
            .i_abort      (abort[g]),
            .o_inbuf_re   (re[g]),
            .o_inbuf_addr (addr[g]),
            .i_inbuf_dat  (dat[g]),
            .o_spi_start  (sstart[g]),
            .o_spi_data   (sdata[g]),
            .i_spi_busy   (sbusy[g]),
            .i_spi_done   (sdone[g]),
            .o_busy       (busy[g]),
            .o_done       (done[g]),
            .o_word_count (wcount[g])
        );
    end

    function automatic int gap_of(input int g);
        return (g == 0) ? 0 : 5;
    endfunction

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (re[g]) dat[g] <= mem[addr[g][5:0]];
        end
    end

    // SPI master: done pulse Lat cycles after start; optional busy tail covering ARM for Hold cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                spi_act[g]   <= 1'b0;
                spi_cnt[g]   <= 0;
                spi_tail[g]  <= 0;
                spi_ndone[g] <= 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (sstart[g]) begin
                    spi_act[g] <= 1'b1;
                    spi_cnt[g] <= Lat - 1;
                end else if (spi_act[g]) begin
                    if (spi_cnt[g] == 0) begin
                        spi_act[g]   <= 1'b0;
                        spi_ndone[g] <= spi_ndone[g] + 1;
                        if (spi_ndone[g] == hold_idx[g]) spi_tail[g] <= 2 + gap_of(g) + Hold;
                    end else begin
                        spi_cnt[g] <= spi_cnt[g] - 1;
                    end
                end else if (spi_tail[g] > 0) begin
                    spi_tail[g] <= spi_tail[g] - 1;
                end
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            sbusy[g] = spi_act[g] || (spi_tail[g] > 0);
            // spurious done one cycle into ARM, stale done alongside the start pulse
            sdone[g] = (spi_act[g] && (spi_cnt[g] == 0)) || (spi_tail[g] == Hold - 1) ||
                       (stale_en[g] && sstart[g]);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < 2; g++) begin
                if (re[g]) begin
                    if (n_re[g] < LogN) begin
                        re_cyc[g][n_re[g]] = cyc;
                        re_adr[g][n_re[g]] = addr[g];
                    end
                    n_re[g]++;
                end
                if (sstart[g]) begin
                    if (n_st[g] < LogN) begin
                        st_cyc[g][n_st[g]] = cyc;
                        st_dat[g][n_st[g]] = sdata[g];
                    end
                    n_st[g]++;
                end
                if (done[g]) begin
                    if (n_done[g] < LogN) dn_cyc[g][n_done[g]] = cyc;
                    n_done[g]++;
                end
                if (busy[g]) n_busy[g]++;
                if ((re[g] && re_prev[g]) || (sstart[g] && st_prev[g])) dbl_err[g]++;
                if ((spi_tail[g] > 0) && (spi_tail[g] <= Hold)) begin
                    hold_n[g]++;
                    if (sdata[g] !== hold_exp[g]) hold_err[g]++;
                end
                re_prev[g] = re[g];
                st_prev[g] = sstart[g];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: re at c0+1 then done+1+gap; start at re+3 (+hold); done at start+Lat
    task automatic run_burst(input int g, input int n, input int hold, input bit stale,
                             input bit poke);
        int c0, b_st, b_re, b_dn, b_bz, t, d, s, gp, exp_re, idx;
        gp   = gap_of(g);
        b_st = n_st[g];
        b_re = n_re[g];
        b_dn = n_done[g];
        b_bz = n_busy[g];
        hold_idx[g] = (hold >= 0) ? spi_ndone[g] + hold : -1;
        if (hold >= 0) hold_exp[g] = mem[hold + 1];
        stale_en[g] = stale;
        bcount[g]   = n[15:0];
        start[g]    = 1'b1;
        c0          = cyc;
        @(negedge clk);
        start[g] = 1'b0;
        t = 0;
        while ((n_done[g] == b_dn) && (t < 600)) begin
            @(negedge clk);
            t++;
            if (poke && (t == 20)) begin
                start[g]  = 1'b1;
                bcount[g] = 16'd1;
            end else begin
                start[g] = 1'b0;
            end
        end
        start[g] = 1'b0;
        check_eq($sformatf("u%0d_n%0d_timeout", g, n), (t < 600), 1);
        repeat (3) @(negedge clk);

        s = c0 + 4;
        d = c0;
        for (int i = 0; i < n; i++) begin
            exp_re = (i == 0) ? c0 + 1 : d + 1 + gp;
            idx = b_st + i;
            if (idx < LogN) begin
                check_eq($sformatf("u%0d_re_cyc%0d", g, i), re_cyc[g][b_re + i] - c0, exp_re - c0);
                check_eq($sformatf("u%0d_re_addr%0d", g, i), re_adr[g][b_re + i], i);
                check_eq($sformatf("u%0d_st_cyc%0d", g, i), st_cyc[g][idx] - c0, s - c0);
                check_eq($sformatf("u%0d_st_data%0d", g, i), st_dat[g][idx], mem[i]);
            end
            d = s + Lat;
            s = d + 4 + gp + ((i == hold) ? Hold : 0);
        end
        check_eq($sformatf("u%0d_n_starts", g), n_st[g] - b_st, n);
        check_eq($sformatf("u%0d_n_reads", g), n_re[g] - b_re, n);
        check_eq($sformatf("u%0d_n_done", g), n_done[g] - b_dn, 1);
        if (b_dn < LogN)
            check_eq($sformatf("u%0d_done_cyc", g), dn_cyc[g][b_dn] - c0,
                     (n == 0) ? 2 : d + 1 - c0);
        check_eq($sformatf("u%0d_busy_cycles", g), n_busy[g] - b_bz, (n == 0) ? 0 : d - c0);
        if (n != 0) last_wc[g] = n;
        check_eq($sformatf("u%0d_word_count", g), wcount[g], last_wc[g]);
        check_eq($sformatf("u%0d_idle_busy", g), busy[g], 0);
        stale_en[g] = 1'b0;
        hold_idx[g] = -1;
    endtask

    task automatic run_abort();
        int b_dn, nd0, t;
        b_dn = n_done[0];
        nd0  = spi_ndone[0];
        bcount[0] = 16'd4;
        start[0]  = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        t = 0;
        while (!(spi_act[0] && (spi_cnt[0] == 0) && (spi_ndone[0] == nd0 + 1)) && (t < 200)) begin
            @(negedge clk);
            t++;
        end
        check_eq("abort_reach_word2", (t < 200), 1);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check_eq("abort_busy", busy[0], 0);
        check_eq("abort_spi_start", sstart[0], 0);
        check_eq("abort_re", re[0], 0);
        check_eq("abort_addr", addr[0], 0);
        check_eq("abort_word_count", wcount[0], 1);
        repeat (6) @(negedge clk);
        check_eq("abort_no_done", n_done[0] - b_dn, 0);
        last_wc[0] = 1;
    endtask

    task automatic run_async_reset();
        int b_dn;
        b_dn = n_done[0];
        bcount[0] = 16'd5;
        start[0]  = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("rst_pre_word_count", wcount[0], 1);
        check_eq("rst_pre_busy", busy[0], 1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_busy", busy[0], 0);
        check_eq("rst_word_count", wcount[0], 0);
        check_eq("rst_spi_data", sdata[0], 0);
        check_eq("rst_spi_start", sstart[0], 0);
        check_eq("rst_re_addr", {re[0], addr[0]}, 0);
        check_eq("rst_done", done[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_no_done", n_done[0] - b_dn, 0);
        last_wc[0] = 0;
        last_wc[1] = 0;
    endtask

    initial begin
        int g, n, hold;
        bit stale;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i]    = 1'b0;
            bcount[i]   = 16'd0;
            abort[i]    = 1'b0;
            hold_idx[i] = -1;
            stale_en[i] = 1'b0;
            hold_exp[i] = 16'd0;
            last_wc[i]  = 0;
        end
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hA5A5;
        mem[1] = 16'h1234;
        mem[2] = 16'hFFFF;
        repeat (2) @(negedge clk);
        check_eq("reset_busy", busy[0], 0);
        check_eq("reset_outputs", {re[0], sstart[0], done[0], addr[0], wcount[0]}, 0);
        check_eq("reset_gap_inst", {busy[1], re[1], sstart[1], done[1]}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_burst(0, 3, -1, 1'b0, 1'b0);
        run_burst(1, 2, -1, 1'b0, 1'b0);
        run_burst(0, 3, 0, 1'b0, 1'b0);
        run_burst(0, 0, -1, 1'b0, 1'b0);
        run_abort();
        run_burst(0, 4, -1, 1'b0, 1'b0);
        run_burst(0, 4, 1, 1'b1, 1'b1);
        run_async_reset();
        run_burst(1, 3, 1, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            g     = int'($urandom_range(0, 1));
            n     = int'($urandom_range(1, 6));
            hold  = ((n > 1) && ($urandom_range(0, 1) == 1)) ? int'($urandom_range(0, n - 2)) : -1;
            stale = 1'($urandom_range(0, 1));
            run_burst(g, n, hold, stale, 1'b0);
        end

        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("u%0d_no_double_pulse", i), dbl_err[i], 0);
            check_eq($sformatf("u%0d_hold_data_stable", i), hold_err[i], 0);
        end
        check_eq("hold_exercised", (hold_n[0] > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
